// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the MEM/WB pipeline register.
//   mem_wb_t : the bundle that travels from the memory stage to write-back
//   BUBBLE   : the all-zero bundle loaded on reset and flush
//   gateCtl  : forces the controls to 0 unless the bundle is valid
package pipe_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  typedef struct packed {
    logic                  valid;
    logic                  jump;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [DATA_W_DEF-1:0] read_data;
    logic [DATA_W_DEF-1:0] alu_result;
    logic [REG_W_DEF-1:0]  write_reg;
  } mem_wb_t;

  localparam mem_wb_t BUBBLE = '0;

  // An invalid bundle must never write the register file or redirect the PC,
  // whatever the upstream controls say.
  function automatic mem_wb_t gateCtl(input mem_wb_t b);
    mem_wb_t g;
    g            = b;
    g.jump       = b.jump & b.valid;
    g.mem_to_reg = b.mem_to_reg & b.valid;
    g.reg_write  = b.reg_write & b.valid;
    return g;
  endfunction
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one MEM/WB bundle register.
//   clk, rst_n : clock, asynchronous active-low reset (clears to BUBBLE)
//   stall      : hold the current contents
//   flush      : load BUBBLE (wins over stall)
//   d / q      : bundle in / bundle out
module pipe_stage
  import pipe_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    stall,
  input  logic    flush,
  input  mem_wb_t d,
  output mem_wb_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q <= BUBBLE;
    else if (flush)  q <= BUBBLE;
    else if (!stall) q <= d;
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: DEPTH-stage MEM/WB pipeline register with stall/flush,
// write-back mux and optional statistics counters.
//   Params : DATA_W (<= DATA_W_DEF), REG_W (<= REG_W_DEF), DEPTH (1..4)
//   In     : clk, rst_n (async, active low), stall_i, flush_i, valid_i,
//            jump_i, mem_to_reg_i, reg_write_i, read_data_i, alu_result_i,
//            write_reg_i
//   Out    : last-stage bundle (valid_o, jump_o, mem_to_reg_o, reg_write_o,
//            read_data_o, alu_result_o, write_reg_o) and wb_data_o
//   Macro  : PIPE_STAT_EN adds stall_cnt_o / flush_cnt_o (saturating, 16 bit)
module mem_wb_pipe
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              jump_i,
  input  logic              mem_to_reg_i,
  input  logic              reg_write_i,
  input  logic [DATA_W-1:0] read_data_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [REG_W-1:0]  write_reg_i,
  output logic              valid_o,
  output logic              jump_o,
  output logic              mem_to_reg_o,
  output logic              reg_write_o,
  output logic [DATA_W-1:0] read_data_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [REG_W-1:0]  write_reg_o,
  output logic [DATA_W-1:0] wb_data_o
`ifdef PIPE_STAT_EN
  ,
  output logic [15:0]       stall_cnt_o,
  output logic [15:0]       flush_cnt_o
`endif
);

  // stg[0] is the gated input bundle, stg[i+1] is the output of stage i.
  mem_wb_t [DEPTH:0] stg;
  logic    [DEPTH:0] vld_pipe;
  mem_wb_t           inB;

  always_comb begin
    inB            = BUBBLE;
    inB.valid      = valid_i;
    inB.jump       = jump_i;
    inB.mem_to_reg = mem_to_reg_i;
    inB.reg_write  = reg_write_i;
    inB.read_data  = DATA_W_DEF'(read_data_i);
    inB.alu_result = DATA_W_DEF'(alu_result_i);
    inB.write_reg  = REG_W_DEF'(write_reg_i);
  end

  assign stg[0] = gateCtl(inB);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_stage u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .stall (stall_i),
      .flush (flush_i),
      .d     (stg[i]),
      .q     (stg[i+1])
    );
  end

  for (genvar i = 0; i <= DEPTH; i++) begin : g_vld
    assign vld_pipe[i] = stg[i].valid;
  end

  assign valid_o      = vld_pipe[DEPTH];
  assign jump_o       = stg[DEPTH].jump;
  assign mem_to_reg_o = stg[DEPTH].mem_to_reg;
  assign reg_write_o  = stg[DEPTH].reg_write;
  assign read_data_o  = DATA_W'(stg[DEPTH].read_data);
  assign alu_result_o = DATA_W'(stg[DEPTH].alu_result);
  assign write_reg_o  = REG_W'(stg[DEPTH].write_reg);
  assign wb_data_o    = mem_to_reg_o ? read_data_o : alu_result_o;

`ifdef PIPE_STAT_EN
  // A flush edge counts only as a flush, even when stall is also high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else if (flush_i) begin
      if (flush_cnt_o != 16'hFFFF) flush_cnt_o <= flush_cnt_o + 16'd1;
    end else if (stall_i) begin
      if (stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: directed bench for mem_wb_pipe with DEPTH=1 and DEPTH=3
// instances sharing one stimulus stream. A queue-based model gives the
// expected last-stage bundle; literal checks pin the model.
module tb_mem_wb_pipe;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n, stall, flush, vI, jI, mI, rI;
  logic [31:0] rdI, aluI;
  logic [4:0]  wrI;

  logic v1, j1, m1, r1, v3, j3, m3, r3;
  logic [31:0] rd1, alu1, wb1, rd3, alu3, wb3;
  logic [4:0]  wr1, wr3;
`ifdef PIPE_STAT_EN
  logic [15:0] sc1, fc1, sc3, fc3;
`endif

  always #5 clk = ~clk;

  mem_wb_pipe #(.DATA_W(32), .REG_W(5), .DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
    .valid_i(vI), .jump_i(jI), .mem_to_reg_i(mI), .reg_write_i(rI),
    .read_data_i(rdI), .alu_result_i(aluI), .write_reg_i(wrI),
    .valid_o(v1), .jump_o(j1), .mem_to_reg_o(m1), .reg_write_o(r1),
    .read_data_o(rd1), .alu_result_o(alu1), .write_reg_o(wr1), .wb_data_o(wb1)
`ifdef PIPE_STAT_EN
    , .stall_cnt_o(sc1), .flush_cnt_o(fc1)
`endif
  );

  mem_wb_pipe #(.DATA_W(32), .REG_W(5), .DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
    .valid_i(vI), .jump_i(jI), .mem_to_reg_i(mI), .reg_write_i(rI),
    .read_data_i(rdI), .alu_result_i(aluI), .write_reg_i(wrI),
    .valid_o(v3), .jump_o(j3), .mem_to_reg_o(m3), .reg_write_o(r3),
    .read_data_o(rd3), .alu_result_o(alu3), .write_reg_o(wr3), .wb_data_o(wb3)
`ifdef PIPE_STAT_EN
    , .stall_cnt_o(sc3), .flush_cnt_o(fc3)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the pipe is a DEPTH-long queue of accepted bundles; the output
  // is the oldest entry. Stall freezes the queue, flush refills it with bubbles.
  mem_wb_t q1[$], q3[$];
  logic [15:0] mSc, mFc;

  function automatic mem_wb_t inBundle();
    mem_wb_t b;
    b.valid      = vI;
    b.jump       = jI & vI;
    b.mem_to_reg = mI & vI;
    b.reg_write  = rI & vI;
    b.read_data  = rdI;
    b.alu_result = aluI;
    b.write_reg  = wrI;
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 = {BUBBLE};
      q3 = {BUBBLE, BUBBLE, BUBBLE};
      mSc = 16'd0;
      mFc = 16'd0;
    end else if (flush) begin
      q1 = {BUBBLE};
      q3 = {BUBBLE, BUBBLE, BUBBLE};
      if (mFc != 16'hFFFF) mFc = mFc + 16'd1;
    end else if (stall) begin
      if (mSc != 16'hFFFF) mSc = mSc + 16'd1;
    end else begin
      q1.push_back(inBundle());
      void'(q1.pop_front());
      q3.push_back(inBundle());
      void'(q3.pop_front());
    end
  end

  task automatic cmp(input string t, input mem_wb_t e, input logic v, j, m, r,
                     input logic [31:0] rd, alu, wb, input logic [4:0] wr);
    chk({t, ".valid"}, 32'(v), 32'(e.valid));
    chk({t, ".jump"}, 32'(j), 32'(e.jump));
    chk({t, ".mem_to_reg"}, 32'(m), 32'(e.mem_to_reg));
    chk({t, ".reg_write"}, 32'(r), 32'(e.reg_write));
    chk({t, ".read_data"}, rd, e.read_data);
    chk({t, ".alu_result"}, alu, e.alu_result);
    chk({t, ".write_reg"}, 32'(wr), 32'(e.write_reg));
    chk({t, ".wb_data"}, wb, e.mem_to_reg ? e.read_data : e.alu_result);
  endtask

  always @(negedge clk) begin
    if (q1.size() == 1 && q3.size() == 3) begin
      cmp("d1", q1[0], v1, j1, m1, r1, rd1, alu1, wb1, wr1);
      cmp("d3", q3[0], v3, j3, m3, r3, rd3, alu3, wb3, wr3);
`ifdef PIPE_STAT_EN
      chk("d1.stall_cnt", 32'(sc1), 32'(mSc));
      chk("d1.flush_cnt", 32'(fc1), 32'(mFc));
      chk("d3.stall_cnt", 32'(sc3), 32'(mSc));
      chk("d3.flush_cnt", 32'(fc3), 32'(mFc));
`endif
    end
  end

  task automatic drv(input logic v, j, m, r, input logic [31:0] rd, alu, input logic [4:0] wr);
    vI = v; jI = j; mI = m; rI = r; rdI = rd; aluI = alu; wrI = wr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp3[11] = '{0, 0, 11, 11, 11, 12, 13, 14, 15, 16, 0};

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    #8;
    chk("rst.v1", 32'(v1), 0);
    chk("rst.v3", 32'(v3), 0);
    chk("rst.wb3", wb3, 0);
    #4 rst_n = 1'b1;

    // DEPTH=1 single bundle and wb mux select
    drv(1, 0, 1, 1, 32'hDEADBEEF, 32'h10, 5'd9);
    step();
    chk("t1.valid", 32'(v1), 1);
    chk("t1.write_reg", 32'(wr1), 9);
    chk("t1.wb_rd", wb1, 32'hDEADBEEF);
    mI = 1'b0;
    step();
    chk("t1.wb_alu", wb1, 32'h10);

    // DEPTH=3 streaming latency
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) drv(1, 0, 0, 1, 0, 32'(k), 5'(k));
      else        drv(0, 0, 0, 0, 0, 0, 0);
      step();
      if (k >= 3) chk("t2.alu3", alu3, 32'(k - 2));
    end

    // DEPTH=3 with a two-cycle stall mid-stream
    for (int k = 0; k < 11; k++) begin
      stall = 1'b0;
      if (k < 3)      drv(1, 0, 0, 1, 0, 32'(11 + k), 5'd1);
      else if (k < 5) begin drv(1, 0, 0, 1, 0, 32'd14, 5'd1); stall = 1'b1; end
      else if (k < 8) drv(1, 0, 0, 1, 0, 32'(14 + k - 5), 5'd1);
      else            drv(0, 0, 0, 0, 0, 0, 0);
      step();
      chk("t3.alu3", alu3, 32'(exp3[k]));
    end
    stall = 1'b0;

    // flush beats stall with data in flight
    drv(1, 0, 0, 1, 0, 32'h55, 5'd3);
    step();
    step();
    chk("t4.pre_v3", 32'(v3), 0);
    stall = 1'b1; flush = 1'b1;
    step();
    chk("t4.v3", 32'(v3), 0);
    chk("t4.r3", 32'(r3), 0);
    chk("t4.wb3", wb3, 0);
    chk("t4.v1", 32'(v1), 0);
    chk("t4.wb1", wb1, 0);
`ifdef PIPE_STAT_EN
    chk("t4.flush_cnt", 32'(fc3), 1);
    chk("t4.stall_cnt", 32'(sc3), 2);
`endif
    stall = 1'b0; flush = 1'b0;

    // invalid bundle with write/jump controls set
    drv(0, 1, 0, 1, 32'hAA, 32'hBB, 5'd7);
    step();
    chk("t5.r1", 32'(r1), 0);
    chk("t5.j1", 32'(j1), 0);
    chk("t5.alu1", alu1, 32'hBB);
    step();
    step();
    chk("t5.r3", 32'(r3), 0);
    chk("t5.j3", 32'(j3), 0);
    chk("t5.alu3", alu3, 32'hBB);

    // asynchronous reset with a full pipe
    drv(1, 1, 1, 1, 32'h1234, 32'h5678, 5'd4);
    step();
    step();
    step();
    chk("t6.full_v3", 32'(v3), 1);
    chk("t6.full_wb3", wb3, 32'h1234);
    #1 rst_n = 1'b0;
    #1;
    chk("t6.v1", 32'(v1), 0);
    chk("t6.v3", 32'(v3), 0);
    chk("t6.r3", 32'(r3), 0);
    chk("t6.j3", 32'(j3), 0);
    chk("t6.wb1", wb1, 0);
    chk("t6.wb3", wb3, 0);
    chk("t6.wr3", 32'(wr3), 0);
    #1 rst_n = 1'b1;

`ifdef PIPE_STAT_EN
    stall = 1'b1;
    repeat (70000) step();
    chk("t7.stall_sat", 32'(sc3), 32'hFFFF);
    chk("t7.flush_cnt", 32'(fc3), 0);
    stall = 1'b0;
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM/WB pipeline register for the single-clock MIPS datapath. It carries the memory-stage result bundle to write-back:
- jump, mem_to_reg and reg_write controls
- read data, ALU result and destination register

The bundle passes through DEPTH register stages, with a per-stage valid bit, stall (hold) and flush (bubble) control. It also selects the final write-back value. It sits between the data-memory stage and the register file and replaces the fixed single-stage MEM/WB buffer.

## Interface
- DATA_W, 32, width of read data, ALU result and write-back value
- REG_W, 5, width of destination register index
- DEPTH, 1, number of register stages (1..4)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hold all stages
- flush_i  in  1  invalidate all stages (bubble)
- valid_i  in  1  incoming bundle is a real instruction
- jump_i  in  1  jump control
- mem_to_reg_i  in  1  select read data for write-back
- reg_write_i  in  1  register-file write enable
- read_data_i  in  DATA_W  data-memory read value
- alu_result_i  in  DATA_W  ALU result
- write_reg_i  in  REG_W  destination register
- valid_o  out  1  last-stage valid
- jump_o, mem_to_reg_o, reg_write_o  out  1 each  last-stage controls
- read_data_o, alu_result_o  out  DATA_W  last-stage data
- write_reg_o  out  REG_W  last-stage destination
- wb_data_o  out  DATA_W  mem_to_reg_o ? read_data_o : alu_result_o
- stall_cnt_o, flush_cnt_o  out  16 each  statistics (only with PIPE_STAT_EN)

## Operation
- Stage 0 captures the inputs; stage k captures stage k-1; outputs come from stage DEPTH-1.
- Normal cycle (no stall, no flush): every stage advances.
- stall_i=1, flush_i=0:
  - all stages, valid bits included, hold their contents
  - inputs are ignored and not buffered; upstream must hold them
- flush_i=1:
  - every stage loads the bubble: valid=0, all controls=0, data and register index=0
  - flush takes priority over stall when both are asserted
- Bubble gating:
  - a stage with valid=0 always presents reg_write_o=0 and jump_o=0
  - this holds even if valid_i=0 arrived with reg_write_i=1, because the controls are ANDed with valid on capture
- wb_data_o is purely combinational from the last stage and needs no extra register.
- Reset mid-operation: all stages are cleared immediately (asynchronous), with no wait for a clock edge; contents in flight are discarded.

## Timing
- Latency: an input captured at edge n appears on the outputs after edge n+DEPTH-1, i.e. DEPTH edges in total, with no stalls.
- Each stall cycle adds exactly one cycle of latency to every bundle in flight.
- Flush takes effect at the next rising edge; outputs are bubble-valued from that edge onward.
- Reset values: all outputs 0, including valid_o, wb_data_o and both counters.
- Throughput: one bundle per cycle when stall_i=0.

## Configuration
- PIPE_STAT_EN defined:
  - stall_cnt_o increments on every edge with stall_i=1 and flush_i=0
  - flush_cnt_o increments on every edge with flush_i=1
  - both saturate at 16'hFFFF (no wrap) and reset to 0
- PIPE_STAT_EN undefined: the counters, their ports and their logic are absent.

## Structure
- Shared package pipe_pkg holds:
  - the typedef of the MEM/WB bundle struct (valid, jump, mem_to_reg, reg_write, read_data, alu_result, write_reg), parametrised through package constants DATA_W_DEF=32 and REG_W_DEF=5
  - the constant BUBBLE (all-zero bundle)
- One sub-module, pipe_stage: a single bundle register with stall/flush/async reset. mem_wb_pipe instantiates DEPTH copies through a generate loop, plus the wb mux and the optional counters.

## Test plan
- Reset, then DEPTH=1. Feed valid_i=1, reg_write_i=1, mem_to_reg_i=1, read_data_i=32'hDEADBEEF, alu_result_i=32'h10, write_reg_i=5'd9 → after one edge: valid_o=1, write_reg_o=9, wb_data_o=32'hDEADBEEF. Then set mem_to_reg_i=0 → wb_data_o=32'h10 after the next edge.
- DEPTH=3, one bundle per cycle (values 1,2,3,4) → alu_result_o shows 1,2,3,4 on consecutive cycles, starting 3 edges after the first input.
- DEPTH=3, assert stall_i for 2 cycles mid-stream → outputs hold for 2 cycles, then resume with no bundle lost or duplicated.
- Assert stall_i and flush_i together with valid data in flight → after the next edge: valid_o=0, reg_write_o=0, wb_data_o=0. With PIPE_STAT_EN: flush_cnt_o=1, stall_cnt_o unchanged.
- Set valid_i=0 with reg_write_i=1 and jump_i=1 → the bundle emerges with reg_write_o=0 and jump_o=0.
- Pull rst_n low between clock edges while the pipe is full → all outputs read 0 before the next rising edge. With PIPE_STAT_EN: force 70000 stall cycles → stall_cnt_o=16'hFFFF.
